// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the ALU result display: converter state encoding,
// active-low seven-segment patterns ({g,f,e,d,c,b,a}), digit count and small
// helper functions for the double-dabble step and segment lookup.
// The hex patterns (A..F) are only referenced when DISPLAY_HEX_EN is defined.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: a BCD nibble of 5 or more would overflow
    // past 9 after the next doubling, so pre-add 3.
    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg_dec(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_BLANK;
        case (n)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_hex(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_BLANK;
        case (n)
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            4'hF:    s = SEG_F;
            default: s = seg_dec(n);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin_to_bcd8.sv
// bin_to_bcd8
// Sequential shift-add-3 (double-dabble) converter, 8-bit binary to three
// BCD digits. One latch cycle, eight shift cycles, one load cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 begin a conversion of bin (honoured in IDLE only)
//   bin[7:0]              value to convert
//   busy                  state != IDLE
//   done                  one-cycle pulse after hundreds/tens/ones update
//   hundreds/tens/ones    registered BCD result
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; on start latch bin, clear BCD, cnt = 0
// SHIFT | adjust nibbles >= 5 by +3, shift {bcd,bin} left; 8 cycles
// LOAD  | copy BCD accumulator to outputs, pulse done, back to IDLE
module bin_to_bcd8
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state, state_nxt;
    logic [7:0]  bin_sr;
    logic [11:0] bcd;
    logic [2:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 3'd7) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr   <= '0;
            bcd      <= '0;
            cnt      <= '0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        bcd    <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    // Hundreds never exceeds 2 for an 8-bit input, so it
                    // needs no correction; only the lower two nibbles do.
                    bcd    <= {bcd[10:8], dd_adj(bcd[7:4]), dd_adj(bcd[3:0]), bin_sr[7]};
                    bin_sr <= {bin_sr[6:0], 1'b0};
                    cnt    <= cnt + 3'd1;
                end
                LOAD: begin
                    hundreds <= bcd[11:8];
                    tens     <= bcd[7:4];
                    ones     <= bcd[3:0];
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/alu_result_display.sv
// alu_result_display
// Shows the 8-bit ALU result in decimal on a 4-digit multiplexed
// seven-segment display with leading-zero blanking. A new result is
// detected against last_val and converted by bin_to_bcd8; changes that
// arrive mid-conversion are picked up as soon as the converter idles.
// Optional feature macro: DISPLAY_HEX_EN adds hex_mode (1 = show last_val
// as two hex digits).
// Ports:
//   clk, rst_n    clock, async active-low reset
//   result[7:0]   ALU result, unsigned
//   hex_mode      (DISPLAY_HEX_EN only) select hex display
//   an[3:0]       digit enables, active-low, an[0] rightmost
//   seg[6:0]      segments {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low, never lit
//   busy          conversion in progress
module alu_result_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 25000
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            result,
`ifdef DISPLAY_HEX_EN
    input  logic                  hex_mode,
`endif
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [7:0]    last_val;
    logic [3:0]    d2, d1, d0;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    digit;
    logic [6:0]    seg_nxt;

    logic          conv_start;
    logic          conv_busy;
    logic          conv_done;
    logic [3:0]    conv_h, conv_t, conv_o;

    assign conv_start = !conv_busy && (result != last_val);

    bin_to_bcd8 u_bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (conv_start),
        .bin      (result),
        .busy     (conv_busy),
        .done     (conv_done),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o)
    );

    always_comb begin
        seg_nxt = SEG_BLANK;
        case (digit)
            2'd0:    seg_nxt = seg_dec(d0);
            2'd1:    if (d2 != 4'd0 || d1 != 4'd0) seg_nxt = seg_dec(d1);
            2'd2:    if (d2 != 4'd0) seg_nxt = seg_dec(d2);
            default: seg_nxt = SEG_BLANK;
        endcase
`ifdef DISPLAY_HEX_EN
        // Reads last_val directly, so toggling hex_mode needs no reconversion.
        if (hex_mode) begin
            case (digit)
                2'd0:    seg_nxt = seg_hex(last_val[3:0]);
                2'd1:    seg_nxt = seg_hex(last_val[7:4]);
                default: seg_nxt = SEG_BLANK;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_val <= '0;
            d2       <= '0;
            d1       <= '0;
            d0       <= '0;
            scan_cnt <= '0;
            digit    <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
            busy     <= 1'b0;
        end else begin
            if (conv_start) last_val <= result;
            if (conv_done) begin
                d2 <= conv_h;
                d1 <= conv_t;
                d0 <= conv_o;
            end
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                digit    <= digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an   <= ~(NUM_DIGITS'(1) << digit);
            seg  <= seg_nxt;
            busy <= conv_busy;
        end
    end

    assign dp = 1'b1;

endmodule
